winograd_ewmm_accum: RTL and testbench

- Winograd F(2x2,3x3) element-wise multiply-accumulate stage, directly upstream of output_2x2_transform.
- Each beat carries one input channel: a transformed input tile V (4x4) and a transformed filter tile U (4x4).
- The block computes V⊙U, accumulates it over channels until the last beat, then presents the 4x4 M tile (256 bits) that the output transform consumes.

---
 rtl/winograd_pkg.sv | 26 ++
 rtl/winograd_ewmm_accum_lane.sv | 39 +++
 rtl/winograd_ewmm_accum.sv | 77 +++++++
 tb/tb_winograd_ewmm_accum.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) pipeline: tile geometry,
// element slicing of packed 4x4 tiles and W-bit saturation.
package winograd_pkg;

    localparam int W     = 16;
    localparam int TILE  = 4;
    localparam int NELEM = TILE * TILE;

    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (W - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (W - 1));

    // Element k = 4i+j lives at [255-16k -: 16], so row 0 occupies the MSBs.
    function automatic logic [W-1:0] elem(input logic [NELEM*W-1:0] bus, input int k);
        return bus[NELEM*W-1-W*k -: W];
    endfunction

    function automatic logic [W-1:0] sat_w(input logic signed [63:0] x);
        if (x > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (x < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end
        return x[W-1:0];
    endfunction

endpackage

// File: rtl/winograd_ewmm_accum_lane.sv
// One element of the EWMM stage: signed multiply, channel accumulate, and the
// shifted/saturated value that the tile register captures on close.
module ewmm_lane
    import winograd_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int FRAC  = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] v,
    input  logic [W-1:0] u,
    input  logic         first,
    input  logic         accept,
    output logic [W-1:0] m_next
);

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] shifted;

    assign prod     = $signed(v) * $signed(u);
    assign prod_ext = ACC_W'(prod);
    // The first beat of a tile overwrites, so no explicit clear is needed between tiles.
    assign acc_next = first ? prod_ext : acc + prod_ext;
    assign shifted  = acc_next >>> FRAC;
    assign m_next   = sat_w(64'(shifted));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc <= '0;
        end else if (accept) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/winograd_ewmm_accum.sv
// Winograd element-wise multiply-accumulate over input channels; presents the
// saturated 4x4 M tile to output_2x2_transform with a valid/ready handshake.
module winograd_ewmm_accum
    import winograd_pkg::*;
#(
    parameter int ACC_W  = 40,
    parameter int FRAC   = 0,
    parameter int MAX_CH = 256
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    input  logic [255:0] V,
    input  logic [255:0] U,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] M,
    output logic [7:0]   ch_count,
    output logic         ovf
);

    localparam logic [7:0] LAST_CNT = 8'(MAX_CH - 1);

    logic         first;
    logic         accept;
    logic         close;
    logic [255:0] m_next;

    // A closing beat may only land when the current M is free or leaving this cycle.
    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign close    = accept && (in_last || ch_count == LAST_CNT);

    for (genvar k = 0; k < NELEM; k++) begin : g_lane
        ewmm_lane #(
            .ACC_W (ACC_W),
            .FRAC  (FRAC)
        ) u_lane (
            .clk    (clk),
            .rstn   (rstn),
            .v      (elem(V, k)),
            .u      (elem(U, k)),
            .first  (first),
            .accept (accept),
            .m_next (m_next[255-W*k -: W])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            M         <= '0;
            out_valid <= 1'b0;
            ch_count  <= '0;
            ovf       <= 1'b0;
            first     <= 1'b1;
        end else if (close) begin
            M         <= m_next;
            out_valid <= 1'b1;
            ch_count  <= '0;
            first     <= 1'b1;
            if (!in_last) begin
                ovf <= 1'b1;
            end
        end else begin
            if (accept) begin
                first    <= 1'b0;
                ch_count <= ch_count + 8'd1;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_winograd_ewmm_accum.sv
// Scoreboard bench for winograd_ewmm_accum: a channel-sum reference model
// queues expected tiles; a monitor pops them on each output handshake.
module tb_winograd_ewmm_accum;

    localparam int MAXCH = 4;
    localparam int FRAC_TB = 0;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_last = 1'b0;
    logic [255:0] V = '0;
    logic [255:0] U = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] M;
    logic [7:0]   ch_count;
    logic         ovf;

    int checks = 0;
    int failures = 0;

    logic [255:0] expQ[$];
    longint       modelAcc[16];
    int           modelCnt = 0;
    bit           modelOvf = 1'b0;
    bit           closePending = 1'b0;
    int           rdyMode = 0;
    bit           heldValid = 1'b0;
    logic [255:0] heldM = '0;

    winograd_ewmm_accum #(
        .ACC_W  (40),
        .FRAC   (FRAC_TB),
        .MAX_CH (MAXCH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .V         (V),
        .U         (U),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .M         (M),
        .ch_count  (ch_count),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    function automatic logic [255:0] expTile();
        logic [255:0] res;
        longint s;
        res = '0;
        for (int k = 0; k < 16; k++) begin
            s = modelAcc[k] >>> FRAC_TB;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            res[255-16*k -: 16] = s[15:0];
        end
        return res;
    endfunction

    // Reference: sum of signed elementwise products since the tile opened.
    task automatic modelAccept(input logic [255:0] v, input logic [255:0] u, input logic last);
        logic [15:0] ve;
        logic [15:0] ue;
        longint p;
        for (int k = 0; k < 16; k++) begin
            ve = v[255-16*k -: 16];
            ue = u[255-16*k -: 16];
            p = longint'($signed(ve)) * longint'($signed(ue));
            modelAcc[k] = (modelCnt == 0) ? p : modelAcc[k] + p;
        end
        if (last || modelCnt == MAXCH - 1) begin
            expQ.push_back(expTile());
            closePending = 1'b1;
            if (!last) modelOvf = 1'b1;
            modelCnt = 0;
        end else begin
            modelCnt++;
        end
    endtask

    task automatic applyStimulus(input logic [255:0] v, input logic [255:0] u, input logic last);
        int waitCycles;
        bit accepted;
        waitCycles = 0;
        accepted = 1'b0;
        @(negedge clk);
        #2;
        V = v;
        U = u;
        in_last = last;
        in_valid = 1'b1;
        while (!accepted) begin
            #2;
            checkOutput("ch_count", 256'(ch_count), 256'(modelCnt));
            if (in_ready) begin
                accepted = 1'b1;
                modelAccept(v, u, last);
            end else begin
                waitCycles++;
                if (waitCycles > 200) begin
                    checkOutput("accept_timeout", 256'(waitCycles), 256'(0));
                    break;
                end
                @(negedge clk);
                #2;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int waitCycles;
        rdyMode = 0;
        idle(1);
        waitCycles = 0;
        while ((expQ.size() != 0 || out_valid) && waitCycles < 100) begin
            idle(1);
            waitCycles++;
        end
        checkOutput("drain", 256'(expQ.size()), 256'(0));
    endtask

    function automatic logic [255:0] fill(input logic [15:0] x);
        return {16{x}};
    endfunction

    // Monitor: choose out_ready, then compare whatever the next edge will hand off.
    initial begin
        forever begin
            @(negedge clk);
            case (rdyMode)
                0: out_ready = 1'b1;
                1: out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            #1;
            if (rstn) begin
                if (closePending) begin
                    checkOutput("latency_out_valid", 256'(out_valid), 256'(1));
                    closePending = 1'b0;
                end
                if (heldValid) begin
                    checkOutput("stall_M_stable", M, heldM);
                    checkOutput("stall_valid_held", 256'(out_valid), 256'(1));
                end
                checkOutput("ovf", 256'(ovf), 256'(modelOvf));
                heldValid = 1'b0;
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_tile", M, '0);
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_tile actual=1 expected=0");
                    end else begin
                        checkOutput("M_tile", M, expQ.pop_front());
                    end
                end else if (out_valid) begin
                    heldValid = 1'b1;
                    heldM = M;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] uPat;
        logic [255:0] rv;
        logic [255:0] ru;
        int len;
        uPat = 256'h0001000100010001000200020002000200030003000300030004000400040004;
        for (int k = 0; k < 16; k++) modelAcc[k] = 0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("reset_M", M, '0);
        checkOutput("reset_ch_count", 256'(ch_count), 256'(0));
        checkOutput("reset_ovf", 256'(ovf), 256'(0));
        #1;
        rstn = 1'b1;

        rdyMode = 0;
        applyStimulus(fill(16'h0001), uPat, 1'b1);
        idle(2);
        repeat (3) applyStimulus(fill(16'h0001), uPat, 1'b0);
        applyStimulus(fill(16'h0001), uPat, 1'b1);
        applyStimulus(fill(16'h7FFF), fill(16'h7FFF), 1'b1);
        applyStimulus(fill(16'hFFFF), fill(16'h0002), 1'b1);
        applyStimulus(fill(16'h8000), fill(16'h7FFF), 1'b0);
        applyStimulus(fill(16'h8000), fill(16'h7FFF), 1'b1);
        drain();

        // Stall: held tile must stay put and block further input.
        rdyMode = 1;
        applyStimulus(fill(16'h0003), fill(16'h0005), 1'b1);
        idle(3);
        #2;
        checkOutput("stall_in_ready", 256'(in_ready), 256'(0));
        rdyMode = 0;
        applyStimulus(fill(16'h0002), fill(16'h0002), 1'b0);
        applyStimulus(fill(16'h0002), fill(16'h0003), 1'b1);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(fill(16'(t + 1)), fill(16'h0010), 1'b1);
        end
        drain();

        repeat (4) applyStimulus(fill(16'h0001), fill(16'h0001), 1'b0);
        applyStimulus(fill(16'h0006), fill(16'hFFFD), 1'b1);
        drain();

        for (int t = 0; t < 40; t++) begin
            rdyMode = 2;
            len = $urandom_range(1, 5);
            for (int b = 0; b < len; b++) begin
                for (int w = 0; w < 8; w++) begin
                    rv[32*w +: 32] = $urandom;
                    ru[32*w +: 32] = $urandom;
                end
                if ($urandom_range(0, 2) == 0) rv = rv & {16{16'h00FF}};
                applyStimulus(rv, ru, b == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();

        // Mid-tile reset discards the partial sum.
        applyStimulus(fill(16'h0009), fill(16'h0009), 1'b0);
        applyStimulus(fill(16'h0009), fill(16'h0009), 1'b0);
        @(negedge clk);
        #2;
        in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        modelCnt = 0;
        modelOvf = 1'b0;
        checkOutput("midreset_out_valid", 256'(out_valid), 256'(0));
        checkOutput("midreset_M", M, '0);
        checkOutput("midreset_ch_count", 256'(ch_count), 256'(0));
        checkOutput("midreset_ovf", 256'(ovf), 256'(0));
        @(negedge clk);
        #2;
        rstn = 1'b1;
        applyStimulus(fill(16'h0002), fill(16'h0002), 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
